// File: rtl/bch_dec_arbiter.sv
// bch_dec_arbiter
//   Shares a single BCH decode engine between N_REQ requesters one codeword
//   at a time. A round-robin pick in IDLE selects the owner (gid). The owner's
//   beats are streamed to the engine in XFER. The arbiter then waits for the
//   engine's done pulse in WAIT, with an optional timeout. The result is
//   presented only to the owner in RESP until that owner takes it.
module bch_dec_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BITS    = 8,
  parameter int BEATS   = 12,
  parameter int T       = 4,
  parameter int TIMEOUT = 64,
  localparam int ERR_W  = $clog2(T + 2),
  localparam int GID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester beat streams
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*BITS-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  // decode engine
  output logic                  eng_valid,
  output logic [BITS-1:0]       eng_data,
  output logic                  eng_start,
  input  logic                  eng_ready,
  input  logic                  eng_done,
  input  logic [ERR_W-1:0]      eng_err_cnt,
  input  logic                  eng_fail,
  // per-requester result
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [ERR_W-1:0]      rsp_err_cnt,
  output logic                  rsp_fail,
  input  logic [N_REQ-1:0]      rsp_ready,
  // status
  output logic                  busy,
  output logic [GID_W-1:0]      grant_id,
  output logic                  proto_err
);

  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Timer value seen in the last WAIT cycle before the timeout fires.
  localparam logic [TMR_W-1:0] TMR_LAST =
    (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
  localparam logic [GID_W-1:0]  GID_LAST  = GID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [GID_W-1:0]     gid_q, gid_d;
  logic [GID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [ERR_W-1:0]     rsp_err_q, rsp_err_d;
  logic                 rsp_fail_q, rsp_fail_d;
  logic                 proto_err_q, proto_err_d;

  logic [BITS-1:0]      req_beat [N_REQ];
  logic                 pick_found;
  logic [GID_W-1:0]     pick_id;
  logic [GID_W-1:0]     pick_next_ptr;
  logic [GID_W:0]       pick_sum;
  logic                 owner_valid;
  logic                 beat_move;

  // Split the flat request bus into one beat per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_beat[g] = req_data[g*BITS +: BITS];
  end

  // Round-robin pick: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_id    = rr_ptr_q;
    pick_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_sum = {1'b0, rr_ptr_q} + (GID_W + 1)'(i);
      if (pick_sum >= (GID_W + 1)'(N_REQ)) begin
        pick_sum = pick_sum - (GID_W + 1)'(N_REQ);
      end
      if (!pick_found && req_valid[pick_sum[GID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = pick_sum[GID_W-1:0];
      end
    end
    pick_next_ptr = (pick_id == GID_LAST) ? '0 : pick_id + GID_W'(1);
  end

  // Next-state logic and all handshake outputs of the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    timer_d     = timer_q;
    rsp_err_d   = rsp_err_q;
    rsp_fail_d  = rsp_fail_q;
    eng_valid   = 1'b0;
    eng_data    = '0;
    eng_start   = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    owner_valid = req_valid[gid_q];
    beat_move   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Granting takes this cycle; the first beat can move next cycle.
        if (pick_found) begin
          gid_d      = pick_id;
          rr_ptr_d   = pick_next_ptr;
          beat_cnt_d = '0;
          state_d    = S_XFER;
        end
      end

      S_XFER: begin
        eng_valid        = owner_valid;
        eng_data         = req_beat[gid_q];
        eng_start        = owner_valid && (beat_cnt_q == '0);
        req_ready[gid_q] = eng_ready;
        beat_move        = owner_valid && eng_ready;
        if (beat_move) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (beat_cnt_q == BEAT_LAST) begin
            timer_d = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // A done pulse wins over a timeout expiring in the same cycle.
        if (eng_done) begin
          rsp_err_d  = eng_err_cnt;
          rsp_fail_d = eng_fail;
          state_d    = S_RESP;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          rsp_err_d  = '0;
          rsp_fail_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_RESP: begin
        rsp_valid[gid_q] = 1'b1;
        if (rsp_ready[gid_q]) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A done pulse outside WAIT is a protocol error that stays set until reset.
  always_comb begin
    proto_err_d = proto_err_q | (eng_done && (state_q != S_WAIT));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      gid_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      timer_q     <= '0;
      rsp_err_q   <= '0;
      rsp_fail_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      timer_q     <= timer_d;
      rsp_err_q   <= rsp_err_d;
      rsp_fail_q  <= rsp_fail_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign grant_id    = gid_q;
  assign rsp_err_cnt = rsp_err_q;
  assign rsp_fail    = rsp_fail_q;
  assign proto_err   = proto_err_q;

  // Structural invariants of the handshake outputs.
  a_rsp_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(rsp_valid));
  a_start_valid : assert property (@(posedge clk) disable iff (reset)
    eng_start |-> eng_valid);
  a_ready_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

endmodule
